// File: rtl/exc_redirect_ctrl.sv
// Flush / redirect sequencer for WB exceptions and ertn: drains wrong-path
// instruction responses, then presents the new fetch PC to IF via valid/ready.
module exc_redirect_ctrl #(
  parameter int MAX_OUT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_exc,
  input  logic        ertn_flush,
  input  logic [31:0] ex_entry,
  input  logic [31:0] era_pc,
  input  logic        inst_req_fire,
  input  logic        inst_resp_fire,
  input  logic        redirect_ready,
  output logic        flush,
  output logic        fetch_hold,
  output logic        req_block,
  output logic        inst_discard,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int CW = $clog2(MAX_OUT + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    REDIR = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [31:0] redirect_pc_q, redirect_pc_d;
  logic        redirect_valid_q;
  logic        fetch_hold_q;
  logic        req_block_q;
  logic        evt;

  always_comb begin
    evt          = (wb_exc | ertn_flush) & (state_q == IDLE);
    flush        = evt;
    inst_discard = inst_resp_fire & (evt | (state_q == DRAIN));

    // Outstanding count saturates on illegal over/underflow stimulus.
    cnt_d = cnt_q;
    if (inst_req_fire && !inst_resp_fire && (cnt_q != MAX_CNT)) begin
      cnt_d = cnt_q + CW'(1);
    end else if (inst_resp_fire && !inst_req_fire && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end

    state_d       = state_q;
    stale_d       = stale_q;
    redirect_pc_d = redirect_pc_q;
    case (state_q)
      IDLE: begin
        if (evt) begin
          // cnt_d already folds in a request/response fired in the flush cycle.
          stale_d       = cnt_d;
          redirect_pc_d = wb_exc ? ex_entry : era_pc;
          state_d       = (cnt_d != '0) ? DRAIN : REDIR;
        end
      end
      DRAIN: begin
        if (inst_resp_fire && (stale_q != '0)) begin
          stale_d = stale_q - CW'(1);
        end
        if ((stale_q == '0) || ((stale_q == CW'(1)) && inst_resp_fire)) begin
          state_d = REDIR;
        end
      end
      REDIR: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= IDLE;
      cnt_q            <= '0;
      stale_q          <= '0;
      redirect_pc_q    <= '0;
      redirect_valid_q <= 1'b0;
      fetch_hold_q     <= 1'b0;
      req_block_q      <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      stale_q          <= stale_d;
      redirect_pc_q    <= redirect_pc_d;
      redirect_valid_q <= (state_d == REDIR);
      fetch_hold_q     <= (state_d != IDLE);
      req_block_q      <= (cnt_d == MAX_CNT);
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign fetch_hold     = fetch_hold_q;
  assign req_block      = req_block_q;
  assign redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_exc_redirect_ctrl.sv
// Directed bench for exc_redirect_ctrl: hand-computed expectations per cycle,
// inputs driven 1 ns after posedge and outputs sampled 1 ns after that.
module tb_exc_redirect_ctrl;

  logic        clk;
  logic        resetn;
  logic        wb_exc;
  logic        ertn_flush;
  logic [31:0] ex_entry;
  logic [31:0] era_pc;
  logic        inst_req_fire;
  logic        inst_resp_fire;
  logic        redirect_ready;
  logic        flush;
  logic        fetch_hold;
  logic        req_block;
  logic        inst_discard;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int testCount;
  int failCount;

  localparam logic [31:0] EENTRY = 32'h1c008000;
  localparam logic [31:0] ERA    = 32'h1c000100;

  exc_redirect_ctrl #(.MAX_OUT(2)) dut (
    .clk            (clk),
    .resetn         (resetn),
    .wb_exc         (wb_exc),
    .ertn_flush     (ertn_flush),
    .ex_entry       (ex_entry),
    .era_pc         (era_pc),
    .inst_req_fire  (inst_req_fire),
    .inst_resp_fire (inst_resp_fire),
    .redirect_ready (redirect_ready),
    .flush          (flush),
    .fetch_hold     (fetch_hold),
    .req_block      (req_block),
    .inst_discard   (inst_discard),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic exc, input logic ertn, input logic req,
                               input logic resp, input logic ready);
    wb_exc         = exc;
    ertn_flush     = ertn;
    inst_req_fire  = req;
    inst_resp_fire = resp;
    redirect_ready = ready;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    testCount  = 0;
    failCount  = 0;
    ex_entry   = EENTRY;
    era_pc     = ERA;
    resetn     = 1'b0;
    applyStimulus(0, 0, 0, 0, 0);
    tick();
    checkOutput("rst_valid", {31'd0, redirect_valid}, 32'd0);
    checkOutput("rst_hold",  {31'd0, fetch_hold}, 32'd0);
    checkOutput("rst_block", {31'd0, req_block}, 32'd0);
    checkOutput("rst_pc",    redirect_pc, 32'd0);
    checkOutput("rst_flush", {31'd0, flush}, 32'd0);
    resetn = 1'b1;
    tick();

    // Scenario 1: exception with nothing outstanding.
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("s1_flush_T", {31'd0, flush}, 32'd1);
    checkOutput("s1_hold_T",  {31'd0, fetch_hold}, 32'd0);
    checkOutput("s1_disc_T",  {31'd0, inst_discard}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s1_flush_T1", {31'd0, flush}, 32'd0);
    checkOutput("s1_valid_T1", {31'd0, redirect_valid}, 32'd1);
    checkOutput("s1_pc_T1",    redirect_pc, EENTRY);
    checkOutput("s1_hold_T1",  {31'd0, fetch_hold}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s1_valid_T2", {31'd0, redirect_valid}, 32'd0);
    checkOutput("s1_hold_T2",  {31'd0, fetch_hold}, 32'd0);

    // Scenario 2: ertn with two requests outstanding.
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("s2_block_c1", {31'd0, req_block}, 32'd0);
    tick();
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("s2_block_c2", {31'd0, req_block}, 32'd1);
    checkOutput("s2_flush_T",  {31'd0, flush}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s2_hold_T1",  {31'd0, fetch_hold}, 32'd1);
    checkOutput("s2_valid_T1", {31'd0, redirect_valid}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s2_disc_T2",  {31'd0, inst_discard}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s2_valid_T3", {31'd0, redirect_valid}, 32'd0);
    checkOutput("s2_disc_T3",  {31'd0, inst_discard}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s2_disc_T4",  {31'd0, inst_discard}, 32'd1);
    checkOutput("s2_valid_T4", {31'd0, redirect_valid}, 32'd0);
    tick();
    for (int c = 5; c <= 7; c++) begin
      applyStimulus(0, 0, 0, 0, (c == 7));
      checkOutput($sformatf("s2_valid_T%0d", c), {31'd0, redirect_valid}, 32'd1);
      checkOutput($sformatf("s2_pc_T%0d", c), redirect_pc, ERA);
      tick();
    end
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s2_valid_T8", {31'd0, redirect_valid}, 32'd0);
    checkOutput("s2_hold_T8",  {31'd0, fetch_hold}, 32'd0);

    // Scenario 3: exception and ertn together, exception target wins.
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("s3_flush_T", {31'd0, flush}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s3_valid_T1", {31'd0, redirect_valid}, 32'd1);
    checkOutput("s3_pc_T1",    redirect_pc, EENTRY);
    tick();
    applyStimulus(0, 0, 0, 0, 0);

    // Scenario 4: cnt=1, request and response both fire in the event cycle.
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 1, 1, 0);
    checkOutput("s4_disc_T",  {31'd0, inst_discard}, 32'd1);
    checkOutput("s4_flush_T", {31'd0, flush}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s4_valid_T1", {31'd0, redirect_valid}, 32'd0);
    checkOutput("s4_disc_T1",  {31'd0, inst_discard}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s4_valid_T2", {31'd0, redirect_valid}, 32'd1);
    checkOutput("s4_cnt_T2",   {30'd0, dut.cnt_q}, 32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s4_hold_T3",  {31'd0, fetch_hold}, 32'd0);

    // Scenario 5: back-to-back requests saturate, then event ignored in DRAIN.
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("s5_block_2", {31'd0, req_block}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s5_block_sat", {31'd0, req_block}, 32'd1);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("s5_block_1", {31'd0, req_block}, 32'd0);
    checkOutput("s5_flush_T", {31'd0, flush}, 32'd1);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("s5_flush_drain", {31'd0, flush}, 32'd0);
    checkOutput("s5_hold_drain",  {31'd0, fetch_hold}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s5_disc", {31'd0, inst_discard}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s5_valid", {31'd0, redirect_valid}, 32'd1);
    checkOutput("s5_pc",    redirect_pc, EENTRY);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s5_hold_end", {31'd0, fetch_hold}, 32'd0);

    // Scenario 6: asynchronous reset in the middle of DRAIN with stale=2.
    ex_entry = 32'h1c00a000;
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(0, 0, 1, 0, 0);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s6_hold_drain", {31'd0, fetch_hold}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("s6_rst_hold",  {31'd0, fetch_hold}, 32'd0);
    checkOutput("s6_rst_block", {31'd0, req_block}, 32'd0);
    checkOutput("s6_rst_pc",    redirect_pc, 32'd0);
    checkOutput("s6_rst_valid", {31'd0, redirect_valid}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("s6_no_disc", {31'd0, inst_discard}, 32'd0);
    tick();
    applyStimulus(1, 0, 0, 0, 0);
    checkOutput("s6_flush_T", {31'd0, flush}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 1);
    checkOutput("s6_valid_T1", {31'd0, redirect_valid}, 32'd1);
    checkOutput("s6_pc_T1",    redirect_pc, 32'h1c00a000);
    tick();
    applyStimulus(0, 0, 0, 0, 0);
    checkOutput("s6_hold_T2",  {31'd0, fetch_hold}, 32'd0);
    checkOutput("s6_valid_T2", {31'd0, redirect_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule

// File: doc/exc_redirect_ctrl.md
# exc_redirect_ctrl

Sequences the pipeline-wide flush and fetch redirect triggered by a write-back exception or `ertn` in the 5-stage LoongArch core. It sits between the WB stage (which raises `wb_exc` / `ertn_flush`), the CSR file (which supplies the exception entry and ERA), and the IF stage's instruction-SRAM request port. It tracks outstanding instruction requests, discards the wrong-path responses still in flight after a flush, and only then hands the new PC to IF through a valid/ready handshake.

## Interface
- `MAX_OUT`, default 2: maximum outstanding instruction requests. Counter width is `CW = clog2(MAX_OUT+1)`.
- `clk` input 1: clock.
- `resetn` input 1: asynchronous, active-low reset.
- `wb_exc` input 1: exception committed in WB this cycle.
- `ertn_flush` input 1: `ertn` committed in WB this cycle.
- `ex_entry` input 32: CSR EENTRY value.
- `era_pc` input 32: CSR ERA value.
- `inst_req_fire` input 1: IF request accepted (`req & addr_ok`).
- `inst_resp_fire` input 1: instruction response returned (`data_ok`).
- `redirect_ready` input 1: IF accepts the redirect PC.
- `flush` output 1: cancel all valid bits in IF/ID/EX/MEM/WB.
- `fetch_hold` output 1: IF must not issue requests.
- `req_block` output 1: outstanding count is at `MAX_OUT`.
- `inst_discard` output 1: the current response is wrong-path; IF drops it.
- `redirect_valid` output 1: `redirect_pc` is valid.
- `redirect_pc` output 32: next fetch PC.

## Operation
- States: IDLE, DRAIN, REDIR.
- `evt = (wb_exc | ertn_flush) & (state == IDLE)`. Events in DRAIN or REDIR are ignored.
- `flush = evt`. This is combinational, in the same cycle as the event.
- Target on `evt`: `ex_entry` if `wb_exc`, else `era_pc`. Exception wins when both are asserted. The target is latched into `redirect_pc`.
- Outstanding counter `cnt`:
  - `+1` on `inst_req_fire`, `-1` on `inst_resp_fire`; unchanged when both occur.
  - It runs in all states.
  - `req_block = (cnt == MAX_OUT)`.
  - `req_fire` at `MAX_OUT` without a matching resp, or `resp_fire` at 0 without a matching req, is an illegal stimulus. `cnt` must then hold (saturate).
- Stale counter `stale`:
  - On `evt`, load with `cnt + inst_req_fire - inst_resp_fire`. A request firing in the flush cycle counts as wrong-path.
  - In DRAIN, `-1` per `inst_resp_fire`.
- `inst_discard = inst_resp_fire & (evt | state == DRAIN)`.
- Transitions:
  - IDLE → DRAIN on `evt` when the loaded `stale` is nonzero.
  - IDLE → REDIR on `evt` when the loaded `stale` is zero.
  - DRAIN → REDIR in the cycle `stale == 1 & inst_resp_fire`, or when `stale == 0`.
  - REDIR → IDLE on `redirect_valid & redirect_ready`.
- `redirect_valid = (state == REDIR)`. `redirect_pc` is held stable while valid.
- `fetch_hold = (state != IDLE)`. A `req_fire` during hold is illegal; `cnt` still counts it.

## Timing
- Reset values (async on `resetn` low):
  - state IDLE; `cnt`, `stale`, `redirect_pc` = 0.
  - Registered outputs: `redirect_valid` = 0, `fetch_hold` = 0, `req_block` = 0.
  - `flush` and `inst_discard` follow inputs gated by IDLE.
- Event at cycle T:
  - `flush` = 1 at T only.
  - `fetch_hold` = 1 from T+1.
- Zero stale: `redirect_valid` = 1 at T+1. Minimum event-to-IDLE is 2 cycles (T+1 ready → IDLE at T+2).
- N stale: REDIR begins the cycle after the Nth discarded response.
- `redirect_valid` stays high until ready. No PC change while waiting.
- Reset asserted mid-DRAIN or mid-REDIR returns to IDLE immediately, with all counters cleared. Responses arriving after reset are not discarded; the integration clears the SRAM side on the same reset.
- `wb_exc` is held one cycle by WB (its `ws_valid` clears next cycle). Only the first cycle matters.

## Test plan
- Exception, `cnt` = 0, `ex_entry` = 0x1c008000:
  - `flush` at T.
  - `redirect_valid` = 1 with `redirect_pc` = 0x1c008000 at T+1.
  - `redirect_ready` at T+1 → IDLE and `fetch_hold` = 0 at T+2.
- `ertn` with `cnt` = 2, `era_pc` = 0x1c000100, responses at T+2 and T+4:
  - `inst_discard` = 1 at T+2 and T+4.
  - `redirect_valid` at T+5, PC 0x1c000100.
  - `redirect_ready` held low until T+7 → `redirect_valid` stays high T+5..T+7.
- `wb_exc` and `ertn_flush` in the same cycle, `ex_entry` = 0x1c008000, `era_pc` = 0x1c000100 → `redirect_pc` = 0x1c008000.
- `cnt` = 1, with `inst_req_fire` and `inst_resp_fire` both at T with the event:
  - `inst_discard` at T.
  - `stale` = 1.
  - One more discard before REDIR; `cnt` = 0 after it.
- `MAX_OUT` = 2, two back-to-back `req_fire`:
  - `req_block` = 1.
  - A `resp_fire` drops it to 0 the next cycle.
  - A second `wb_exc` during DRAIN produces no `flush`.
- `resetn` pulsed low mid-DRAIN (`stale` = 2):
  - Outputs return to reset values asynchronously.
  - Post-reset `wb_exc` behaves as in scenario 1.
